// File: rtl/keypad_pkg.sv
// Shared constants and frame-class encoding for the keypad scanner.
// A class is {valid, multi, code}: valid marks a single key, multi marks ghosting.
package keypad_pkg;
    localparam int NUM_ROWS   = 4;
    localparam int NUM_COLS   = 4;
    localparam int CODE_W     = 4;
    localparam int CLS_W      = CODE_W + 2;
    localparam int FRAME_BITS = NUM_ROWS * NUM_COLS;

    typedef logic [CLS_W-1:0] cls_t;

    localparam cls_t CLS_NONE  = 6'b00_0000;
    localparam cls_t CLS_MULTI = 6'b01_0000;

    function automatic cls_t cls_key(input logic [CODE_W-1:0] code);
        return {1'b1, 1'b0, code};
    endfunction

    function automatic logic cls_is_key(input cls_t cls);
        return cls[CLS_W-1] & ~cls[CLS_W-2];
    endfunction
endpackage

// File: rtl/keypad_debounce.sv
// Frame-stable filter: a class must repeat for FRAMES consecutive evaluations
// before it replaces the committed class. Commit and classes are combinational at i_eval.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int FRAMES = 5
) (
    input  logic s_clk,
    input  logic s_rst_n,
    input  logic i_eval,
    input  cls_t i_cls,
    output logic o_commit,
    output cls_t o_prev_cls,
    output cls_t o_new_cls
);
    localparam int CNT_W = $clog2(FRAMES + 1);

    logic [CNT_W-1:0] r_stable_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    cls_t             r_cand;
    cls_t             r_committed;
    cls_t             w_cand_next;

    always_comb begin
        w_cand_next = r_cand;
        w_cnt_next  = r_stable_cnt;
        if (i_cls == r_cand) begin
            if (r_stable_cnt != CNT_W'(FRAMES))
                w_cnt_next = r_stable_cnt + CNT_W'(1);
        end else begin
            w_cand_next = i_cls;
            w_cnt_next  = CNT_W'(1);
        end
    end

    assign o_commit   = i_eval && (w_cnt_next == CNT_W'(FRAMES)) && (w_cand_next != r_committed);
    assign o_prev_cls = r_committed;
    assign o_new_cls  = w_cand_next;

    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_stable_cnt <= '0;
            r_cand       <= CLS_NONE;
            r_committed  <= CLS_NONE;
        end else if (i_eval) begin
            r_stable_cnt <= w_cnt_next;
            r_cand       <= w_cand_next;
            if (o_commit)
                r_committed <= w_cand_next;
        end
    end
endmodule

// File: rtl/keypad_sel_scan.sv
// 4x4 active-low keypad scanner: column walk, row synchroniser, frame classifier
// and debounced press strobe driving the music-select data_sel/data_sel_en pair.
module keypad_sel_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_CYC        = 50_000,
    parameter int DEBOUNCE_FRAMES = 5
) (
    input  logic                s_clk,
    input  logic                s_rst_n,
    input  logic [NUM_ROWS-1:0] key_row_i,
    output logic [NUM_COLS-1:0] key_col_o,
    output logic [CODE_W-1:0]   data_sel,
    output logic                data_sel_en,
    output logic                key_held
);
    localparam int DW_W = $clog2(SCAN_CYC);

    logic [NUM_ROWS-1:0]   r_row_meta;
    logic [NUM_ROWS-1:0]   r_row_sync;
    logic [NUM_ROWS-1:0]   w_row_act;
    logic [DW_W-1:0]       r_dwell;
    logic [1:0]            r_col_idx;
    logic [FRAME_BITS-1:0] r_frame;
    logic [FRAME_BITS-1:0] w_frame;
    logic                  w_last_dwell;
    logic                  w_frame_end;
    logic [4:0]            w_pop;
    logic [CODE_W-1:0]     w_idx;
    cls_t                  w_cls;
    logic                  w_commit;
    cls_t                  w_prev_cls;
    cls_t                  w_new_cls;

    // Synchroniser resets to "no row pulled low".
    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_row_meta <= '1;
            r_row_sync <= '1;
        end else begin
            r_row_meta <= key_row_i;
            r_row_sync <= r_row_meta;
        end
    end

    assign w_row_act    = ~r_row_sync;
    assign w_last_dwell = (r_dwell == DW_W'(SCAN_CYC - 1));
    assign w_frame_end  = w_last_dwell && (r_col_idx == 2'd3);
    assign key_col_o    = ~(NUM_COLS'(1) << r_col_idx);

    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_dwell   <= '0;
            r_col_idx <= '0;
            r_frame   <= '0;
        end else if (w_last_dwell) begin
            r_dwell   <= '0;
            r_col_idx <= r_col_idx + 2'd1;
            r_frame   <= w_frame;
        end else begin
            r_dwell <= r_dwell + DW_W'(1);
        end
    end

    // Bit index row*NUM_COLS+col equals the key code; the current column is merged
    // in so the classifier sees the complete frame on col 3's last cycle.
    always_comb begin
        w_frame = r_frame;
        for (int r = 0; r < NUM_ROWS; r++)
            for (int c = 0; c < NUM_COLS; c++)
                if (2'(c) == r_col_idx)
                    w_frame[r*NUM_COLS+c] = w_row_act[r];
    end

    always_comb begin
        w_pop = '0;
        w_idx = '0;
        for (int i = 0; i < FRAME_BITS; i++) begin
            if (w_frame[i]) begin
                w_pop = w_pop + 5'd1;
                w_idx = CODE_W'(i);
            end
        end
        if (w_pop == 5'd0)
            w_cls = CLS_NONE;
        else if (w_pop == 5'd1)
            w_cls = cls_key(w_idx);
        else
            w_cls = CLS_MULTI;
    end

    keypad_debounce #(
        .FRAMES (DEBOUNCE_FRAMES)
    ) u_debounce (
        .s_clk      (s_clk),
        .s_rst_n    (s_rst_n),
        .i_eval     (w_frame_end),
        .i_cls      (w_cls),
        .o_commit   (w_commit),
        .o_prev_cls (w_prev_cls),
        .o_new_cls  (w_new_cls)
    );

    // Only a NONE -> KEY commit strobes; roll-over and ghosting stay silent.
    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            data_sel    <= '0;
            data_sel_en <= 1'b0;
            key_held    <= 1'b0;
        end else begin
            data_sel_en <= 1'b0;
            if (w_commit) begin
                key_held <= cls_is_key(w_new_cls);
                if ((w_prev_cls == CLS_NONE) && cls_is_key(w_new_cls)) begin
                    data_sel    <= w_new_cls[CODE_W-1:0];
                    data_sel_en <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_keypad_sel_scan.sv
// Directed bench for keypad_sel_scan with SCAN_CYC=4, DEBOUNCE_FRAMES=3 (16-cycle frames);
// the keypad model pulls row r low while key (r,c) is pressed and column c is driven.
module tb_keypad_sel_scan;
    logic        s_clk;
    logic        s_rst_n;
    logic [3:0]  key_row_i;
    logic [3:0]  key_col_o;
    logic [3:0]  data_sel;
    logic        data_sel_en;
    logic        key_held;

    logic [15:0] pressed;
    int          n_pass;
    int          n_fail;
    int          n_total;
    int          strobes;
    int          n0;
    logic        held_hi;
    logic        held_lo;

    keypad_sel_scan #(
        .SCAN_CYC        (4),
        .DEBOUNCE_FRAMES (3)
    ) dut (
        .s_clk       (s_clk),
        .s_rst_n     (s_rst_n),
        .key_row_i   (key_row_i),
        .key_col_o   (key_col_o),
        .data_sel    (data_sel),
        .data_sel_en (data_sel_en),
        .key_held    (key_held)
    );

    initial begin
        s_clk = 1'b0;
        forever #5 s_clk = ~s_clk;
    end

    always_comb begin
        key_row_i = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !key_col_o[c])
                    key_row_i[r] = 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge s_clk);
            #1;
            if (data_sel_en === 1'b1) strobes++;
            if (key_held === 1'b1) held_hi = 1'b1;
            else held_lo = 1'b1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, observed running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        n_pass = 0; n_fail = 0; n_total = 0; strobes = 0;
        held_hi = 1'b0; held_lo = 1'b0;
        pressed = '0;
        s_rst_n = 1'b0;
        repeat (3) @(posedge s_clk);
        @(negedge s_clk);
        chk("rst_col", key_col_o, 4'b1110);
        chk("rst_sel", data_sel, 0);
        chk("rst_en", data_sel_en, 0);
        chk("rst_held", key_held, 0);
        s_rst_n = 1'b1;

        // 1: idle column walk and 10 silent frames
        for (int k = 1; k <= 16; k++) begin
            logic [3:0] exp_col;
            exp_col = ~(4'b0001 << ((k / 4) % 4));
            step(1);
            chk("col_walk", key_col_o, exp_col);
        end
        step(144);
        chk("idle_strobes", strobes, 0);

        // 2: hold r2,c1 from frame start
        pressed = 16'h0200;
        step(47);
        chk("hold_early", strobes, 0);
        step(1);
        chk("hold_strobe", strobes, 1);
        chk("hold_sel", data_sel, 9);
        chk("hold_en", data_sel_en, 1);
        chk("hold_held", key_held, 1);
        step(1);
        chk("hold_en_single", data_sel_en, 0);
        step(63);
        chk("hold_norepeat", strobes, 1);
        pressed = '0;
        step(48);
        chk("rel_held", key_held, 0);
        chk("rel_sel_kept", data_sel, 9);

        // 3: bounce on r0,c3, then a 2-frame bounce just short of debounce
        held_hi = 1'b0;
        repeat (4) begin
            pressed = 16'h0008; step(8);
            pressed = '0;       step(8);
        end
        pressed = 16'h0008; step(32);
        pressed = '0;       step(16);
        pressed = 16'h0008; step(32);
        pressed = '0;       step(48);
        chk("bounce_strobes", strobes, 1);
        chk("bounce_held", held_hi, 0);
        chk("bounce_sel", data_sel, 9);

        // 4: press 5, brief ghosting, roll-over to 14, then committed MULTI
        pressed = 16'h0020;
        step(48);
        chk("ro_strobe", strobes, 2);
        chk("ro_sel", data_sel, 5);
        held_lo = 1'b0;
        pressed = 16'h4020; step(32);
        pressed = 16'h4000; step(48);
        chk("ro_held_thru", held_lo, 0);
        chk("ro_nostrobe", strobes, 2);
        chk("ro_sel_kept", data_sel, 5);
        pressed = 16'h4001; step(48);
        chk("multi_held", key_held, 0);
        chk("multi_nostrobe", strobes, 2);
        pressed = '0; step(48);
        chk("multi_rel", key_held, 0);

        // 5: press 15, release 4 frames, press 0
        pressed = 16'h8000; step(48);
        chk("p15_strobe", strobes, 3);
        chk("p15_sel", data_sel, 15);
        chk("p15_held", key_held, 1);
        pressed = '0; step(64);
        chk("gap_held", key_held, 0);
        pressed = 16'h0001; step(48);
        chk("p0_strobe", strobes, 4);
        chk("p0_sel", data_sel, 0);
        chk("p0_held", key_held, 1);
        pressed = '0; step(48);
        chk("p0_rel", key_held, 0);

        // 6: reset mid-frame while r1,c2 is held
        pressed = 16'h0040; step(48);
        chk("p6_strobe", strobes, 5);
        chk("p6_sel", data_sel, 6);
        step(24);
        s_rst_n = 1'b0;
        #1;
        chk("mid_rst_col", key_col_o, 4'b1110);
        chk("mid_rst_sel", data_sel, 0);
        chk("mid_rst_en", data_sel_en, 0);
        chk("mid_rst_held", key_held, 0);
        @(negedge s_clk);
        @(negedge s_clk);
        s_rst_n = 1'b1;
        n0 = strobes;
        step(47);
        chk("requal_early", strobes, n0);
        step(1);
        chk("requal_strobe", strobes, n0 + 1);
        chk("requal_sel", data_sel, 6);
        chk("requal_held", key_held, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
